// File: rtl/vote_pkg.sv
// Shared types and constants for the 5-seat voting session controller.
package vote_pkg;

   localparam int N_SEATS     = 5;
   localparam int TIMEOUT_DEF = 16;
   localparam int THRESH_DEF  = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OPEN = 2'd1,
      EVAL = 2'd2,
      DONE = 2'd3
   } state_e;

   function automatic logic [2:0] popcount5(input logic [N_SEATS-1:0] v);
      logic [2:0] c;
      c = '0;
      for (int i = 0; i < N_SEATS; i++) begin
         c = c + {2'b00, v[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/vote_window_timer.sv
// Ballot window timer: down-counter loaded on clear, expires at terminal count zero.
module vote_window_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int            TW   = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] LOAD = TW'(TIMEOUT - 1);

   logic [TW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = LOAD;
      end else if (enable && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Zero means the current window cycle is the last one.
   assign expire = (cnt_q == '0);

endmodule

// File: rtl/vote_session_ctrl.sv
// Voting session sequencer: ballot window, per-seat handshake, majority evaluation.
// Optional VOTE_EARLY_CLOSE_EN closes the window as soon as the outcome is decided.
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   OPEN  | ballot window open, seats may cast
//   EVAL  | one cycle, tally and pass computed from ballot register
//   DONE  | result held until next start
module vote_session_ctrl
   import vote_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int THRESH  = THRESH_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [N_SEATS-1:0] cast_valid,
   input  logic [N_SEATS-1:0] cast_val,
   output logic [N_SEATS-1:0] cast_ack,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [2:0]         tally,
   output logic [N_SEATS-1:0] voted,
   output logic               timed_out
);

   localparam logic [2:0] THRESH_L = 3'(THRESH);

   state_e             state_q, state_d;
   logic [N_SEATS-1:0] voted_q, voted_d;
   logic [N_SEATS-1:0] ballot_q, ballot_d;
   logic [2:0]         tally_q, tally_d;
   logic               pass_q, pass_d;
   logic               timed_out_q, timed_out_d;

   logic               tmr_clear, tmr_en, tmr_expire;
   logic [N_SEATS-1:0] open_ack, voted_acc, ballot_acc;
   logic               all_cast, decided;

   vote_window_timer #(
      .TIMEOUT(TIMEOUT)
   ) u_timer (
      .clk   (clk),
      .rst   (rst),
      .clear (tmr_clear),
      .enable(tmr_en),
      .expire(tmr_expire)
   );

   // Acks and the resulting seat/ballot picture, including this cycle's casts.
   assign open_ack   = cast_valid & ~voted_q;
   assign voted_acc  = voted_q | open_ack;
   assign ballot_acc = (ballot_q & ~open_ack) | (cast_val & open_ack);
   assign all_cast   = &voted_acc;

`ifdef VOTE_EARLY_CLOSE_EN
   localparam logic [2:0] NO_LIMIT = 3'(N_SEATS - THRESH);
   logic [2:0] yes_cnt, no_cnt;
   // Unvoted seats always hold a cleared ballot bit, so ballot popcount is yes-so-far.
   assign yes_cnt = popcount5(ballot_acc);
   assign no_cnt  = popcount5(voted_acc & ~ballot_acc);
   assign decided = (yes_cnt >= THRESH_L) || (no_cnt > NO_LIMIT);
`else
   assign decided = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      voted_d     = voted_q;
      ballot_d    = ballot_q;
      tally_d     = tally_q;
      pass_d      = pass_q;
      timed_out_d = timed_out_q;
      cast_ack    = '0;
      tmr_clear   = 1'b0;
      tmr_en      = 1'b0;

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d     = OPEN;
               voted_d     = '0;
               ballot_d    = '0;
               timed_out_d = 1'b0;
               tmr_clear   = 1'b1;
            end
         end
         OPEN: begin
            tmr_en   = 1'b1;
            cast_ack = open_ack;
            voted_d  = voted_acc;
            ballot_d = ballot_acc;
            // All-cast and early decision both win over a simultaneous timer expiry.
            if (all_cast || decided || tmr_expire) begin
               state_d     = EVAL;
               timed_out_d = tmr_expire && !all_cast && !decided;
            end
         end
         EVAL: begin
            tally_d = popcount5(ballot_q);
            pass_d  = (popcount5(ballot_q) >= THRESH_L);
            state_d = DONE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         voted_q     <= '0;
         ballot_q    <= '0;
         tally_q     <= '0;
         pass_q      <= 1'b0;
         timed_out_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         voted_q     <= voted_d;
         ballot_q    <= ballot_d;
         tally_q     <= tally_d;
         pass_q      <= pass_d;
         timed_out_q <= timed_out_d;
      end
   end

   assign busy      = (state_q == OPEN) || (state_q == EVAL);
   assign done      = (state_q == DONE);
   assign pass      = pass_q;
   assign tally     = tally_q;
   assign voted     = voted_q;
   assign timed_out = timed_out_q;

endmodule
